// File: rtl/rec_word_lock.sv
// rec_word_lock: word-alignment hunter for the wclk-domain receiver path.
// Issues bitslip pulses until LOCK_CNT clean commas are seen, then watches
// decoder code errors and drops lock after ERR_LIMIT errors with no comma between them.
//
// state   | meaning
// --------+----------------------------------------------------------
// START   | idle / restart; search counters cleared, waits for pa_ready
// WAIT    | settling time after entry or bitslip (SLIP_WAIT cycles)
// CHECK   | first word after settling: comma -> LOCKING, else bitslip
// LOCKING | collecting commas up to LOCK_CNT; code error -> bitslip
// READY   | aligned; code errors counted, comma clears the count
module rec_word_lock #(
    parameter int                DSIZE     = 10,
    parameter logic [DSIZE-1:0]  COMMA_P   = 10'b0011111001,
    parameter logic [DSIZE-1:0]  COMMA_N   = 10'b1100000110,
    parameter int                SLIP_WAIT = 8,
    parameter int                LOCK_CNT  = 4,
    parameter int                MAX_SLIPS = 10,
    parameter int                ERR_LIMIT = 16
) (
    input  logic             wclk,
    input  logic             reset,
    input  logic             pa_ready,
    input  logic [DSIZE-1:0] data,
    input  logic             code_err,
    output logic             bitslip,
    output logic             ready,
    output logic             align_error,
    output logic [7:0]       slip_cnt,
    output logic [7:0]       lost_cnt,
    output logic [2:0]       state_out
);

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_WAIT    = 3'd1,
        S_CHECK   = 3'd2,
        S_LOCKING = 3'd3,
        S_READY   = 3'd4
    } state_t;

    localparam int              WW         = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam logic [WW-1:0]   WAIT_LAST  = WW'(SLIP_WAIT - 1);
    localparam logic [7:0]      LOCK_LAST  = 8'(LOCK_CNT);
    localparam logic [7:0]      SLIP_LAST  = 8'(MAX_SLIPS);
    localparam logic [7:0]      ERR_LAST   = 8'(ERR_LIMIT);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    comma_cnt;
    logic [7:0]    err_cnt;

    logic          is_comma;
    logic          miss;
    logic [7:0]    slip_nxt;
    logic [7:0]    comma_nxt;
    logic [7:0]    err_nxt;

    // A word carrying a code error is never a valid comma, even if the bits match.
    assign is_comma  = ((data == COMMA_P) || (data == COMMA_N)) && !code_err;
    assign miss      = ((state == S_CHECK) && !is_comma) ||
                       ((state == S_LOCKING) && code_err);
    assign slip_nxt  = slip_cnt + 8'd1;
    assign comma_nxt = comma_cnt + 8'd1;
    assign err_nxt   = err_cnt + 8'd1;
    assign state_out = state;

    // Alignment FSM with all outputs registered.
    always_ff @(posedge wclk) begin
        if (reset) begin
            state       <= S_START;
            wait_cnt    <= '0;
            comma_cnt   <= '0;
            err_cnt     <= '0;
            slip_cnt    <= '0;
            lost_cnt    <= '0;
            bitslip     <= 1'b0;
            ready       <= 1'b0;
            align_error <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            ready   <= (state == S_READY) && pa_ready;

            if (!pa_ready) begin
                state       <= S_START;
                wait_cnt    <= '0;
                comma_cnt   <= '0;
                err_cnt     <= '0;
                slip_cnt    <= '0;
                align_error <= 1'b0;
            end else begin
                case (state)
                    S_START: begin
                        wait_cnt  <= '0;
                        comma_cnt <= '0;
                        err_cnt   <= '0;
                        slip_cnt  <= '0;
                        state     <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            wait_cnt <= '0;
                            state    <= S_CHECK;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (is_comma) begin
                            comma_cnt <= 8'd1;
                            state     <= (LOCK_CNT == 1) ? S_READY : S_LOCKING;
                        end else begin
                            comma_cnt <= '0;
                            wait_cnt  <= '0;
                            state     <= S_WAIT;
                        end
                    end
                    S_LOCKING: begin
                        if (code_err) begin
                            comma_cnt <= '0;
                            wait_cnt  <= '0;
                            state     <= S_WAIT;
                        end else if (is_comma) begin
                            comma_cnt <= comma_nxt;
                            if (comma_nxt == LOCK_LAST) begin
                                state <= S_READY;
                            end
                        end
                    end
                    S_READY: begin
                        if (code_err) begin
                            if (err_nxt == ERR_LAST) begin
                                // Lock loss restarts the hunt without a bitslip.
                                state       <= S_START;
                                err_cnt     <= '0;
                                comma_cnt   <= '0;
                                wait_cnt    <= '0;
                                slip_cnt    <= '0;
                                align_error <= 1'b0;
                                if (lost_cnt != 8'hFF) begin
                                    lost_cnt <= lost_cnt + 8'd1;
                                end
                            end else begin
                                err_cnt <= err_nxt;
                            end
                        end else if (is_comma) begin
                            err_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= S_START;
                    end
                endcase

                // Miss: request one bitslip and count it; rollover flags the failed search.
                if (miss) begin
                    bitslip <= 1'b1;
                    if (slip_nxt == SLIP_LAST) begin
                        align_error <= 1'b1;
                        slip_cnt    <= '0;
                    end else begin
                        slip_cnt <= slip_nxt;
                    end
                end
            end
        end
    end

endmodule
